// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - dual-producer write-back FIFO feeding the register file write port
// Optional build macro WB_FORWARD_EN enables youngest-match data forwarding on fwd1_data/fwd2_data.
`timescale 1ns/1ps
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          wb_ready,
  output logic [AW-1:0] addrw,
  output logic [DW-1:0] din,
  output logic          wren,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  output logic          pend1,
  output logic          pend2,
  output logic [DW-1:0] fwd1_data,
  output logic [DW-1:0] fwd2_data,
  output logic          overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic             w_pop;
  logic             w_mem_req;
  logic             w_alu_req;
  logic             w_mem_acc;
  logic             w_alu_acc;
  logic [CW-1:0]    w_base;
  logic [CW-1:0]    w_after_mem;
  logic [PW-1:0]    w_alu_ptr;
  logic [DEPTH-1:0] w_occ;
  logic             w_hit1;
  logic             w_hit2;

  // mem is slotted ahead of alu, so alu is the first to be dropped when space runs out
  assign w_pop       = (r_count != '0);
  assign w_base      = r_count - CW'(w_pop);
  assign w_mem_req   = mem_valid && (mem_addr != '0);
  assign w_alu_req   = alu_valid && (alu_addr != '0);
  assign w_mem_acc   = w_mem_req && (w_base < C_DEPTH);
  assign w_after_mem = w_base + CW'(w_mem_acc);
  assign w_alu_acc   = w_alu_req && (w_after_mem < C_DEPTH);
  assign w_alu_ptr   = r_wr_ptr + PW'(w_mem_acc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_ptr   <= r_rd_ptr + PW'(w_pop);
      r_wr_ptr   <= r_wr_ptr + PW'(w_mem_acc) + PW'(w_alu_acc);
      r_count    <= w_after_mem + CW'(w_alu_acc);
      r_overflow <= r_overflow | (w_mem_req & ~w_mem_acc) | (w_alu_req & ~w_alu_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_acc) begin
      r_addr[r_wr_ptr] <= mem_addr;
      r_data[r_wr_ptr] <= mem_data;
    end
    if (w_alu_acc) begin
      r_addr[w_alu_ptr] <= alu_addr;
      r_data[w_alu_ptr] <= alu_data;
    end
  end

  always_comb begin
    w_occ  = '0;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ[i] = ({1'b0, PW'(i) - r_rd_ptr} < r_count);
      if (w_occ[i] && (r_addr[i] == addr1)) w_hit1 = 1'b1;
      if (w_occ[i] && (r_addr[i] == addr2)) w_hit2 = 1'b1;
    end
  end

  assign pend1    = w_hit1 && (addr1 != '0);
  assign pend2    = w_hit2 && (addr2 != '0);
  assign wren     = w_pop;
  assign addrw    = w_pop ? r_addr[r_rd_ptr] : '0;
  assign din      = w_pop ? r_data[r_rd_ptr] : '0;
  assign wb_ready = (w_base <= C_DEPTH - CW'(2));
  assign overflow = r_overflow;

`ifdef WB_FORWARD_EN
  // Walk oldest to youngest so the last match seen is the value the register file will end up holding
  always_comb begin
    fwd1_data = '0;
    fwd2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) && (addr1 != '0) && (r_addr[r_rd_ptr + PW'(k)] == addr1))
        fwd1_data = r_data[r_rd_ptr + PW'(k)];
      if ((CW'(k) < r_count) && (addr2 != '0) && (r_addr[r_rd_ptr + PW'(k)] == addr2))
        fwd2_data = r_data[r_rd_ptr + PW'(k)];
    end
  end
`else
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - table vectors, directed corner sequences and random traffic vs a queue model
`timescale 1ns/1ps
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_addr, mem_addr, addr1, addr2;
  logic [31:0] alu_data, mem_data;
  logic        wb_ready, wren, pend1, pend2, overflow;
  logic [4:0]  addrw;
  logic [31:0] din, fwd1_data, fwd2_data;

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_ready(wb_ready), .addrw(addrw), .din(din), .wren(wren),
    .addr1(addr1), .addr2(addr2), .pend1(pend1), .pend2(pend2),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wren;
    logic [4:0]  addrw;
    logic [31:0] din;
    logic        pend1;
    logic        pend2;
    logic        wb_ready;
    logic        overflow;
  } obs_t;

  typedef struct {
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic [4:0]  a1;
    logic [4:0]  a2;
    obs_t        exp;
  } vec_t;

  vec_t        vtab[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [4:0]  q_addr[$];
  logic [31:0] q_data[$];
  bit          m_ovf;

  function automatic obs_t mk(bit w, int a, logic [31:0] d, bit p1, bit p2, bit rdy, bit ov);
    obs_t o;
    o.wren = w; o.addrw = 5'(a); o.din = d; o.pend1 = p1; o.pend2 = p2;
    o.wb_ready = rdy; o.overflow = ov;
    return o;
  endfunction

  task automatic add(bit mv, int ma, logic [31:0] md, bit av, int aa, logic [31:0] ad,
                     int a1, int a2, obs_t e);
    vec_t v;
    v.mv = mv; v.ma = 5'(ma); v.md = md; v.av = av; v.aa = 5'(aa); v.ad = ad;
    v.a1 = 5'(a1); v.a2 = 5'(a2); v.exp = e;
    vtab.push_back(v);
  endtask

  function automatic obs_t actual();
    obs_t o;
    o.wren = wren; o.addrw = addrw; o.din = din; o.pend1 = pend1; o.pend2 = pend2;
    o.wb_ready = wb_ready; o.overflow = overflow;
    return o;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got wren=%0b addrw=%0d din=%h pend=%0b%0b rdy=%0b ovf=%0b, want wren=%0b addrw=%0d din=%h pend=%0b%0b rdy=%0b ovf=%0b",
               name, act.wren, act.addrw, act.din, act.pend1, act.pend2, act.wb_ready, act.overflow,
               exp.wren, exp.addrw, exp.din, exp.pend1, exp.pend2, exp.wb_ready, exp.overflow);
    end
  endtask

  task automatic check_fwd(string name, logic [31:0] e1, logic [31:0] e2);
    n_vec++;
    if (fwd1_data !== e1 || fwd2_data !== e2) begin
      n_bad++;
      $display("FAIL %s: got fwd1=%h fwd2=%h, want fwd1=%h fwd2=%h", name, fwd1_data, fwd2_data, e1, e2);
    end
  endtask

  // Reference model: a plain queue of pending writes in program order
  function automatic bit in_queue(logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q_addr[j]) if (q_addr[j] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] youngest(logic [4:0] a);
    logic [31:0] v = '0;
`ifdef WB_FORWARD_EN
    if (a != 5'd0) foreach (q_addr[j]) if (q_addr[j] == a) v = q_data[j];
`endif
    return v;
  endfunction

  function automatic obs_t model_obs();
    int n = q_addr.size();
    int after_pop = (n > 0) ? n - 1 : 0;
    return mk(n > 0, (n > 0) ? int'(q_addr[0]) : 0, (n > 0) ? q_data[0] : 32'h0,
              in_queue(addr1), in_queue(addr2), after_pop <= DEPTH - 2, m_ovf);
  endfunction

  task automatic model_clear();
    q_addr.delete(); q_data.delete(); m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    if (q_addr.size() > 0) begin
      void'(q_addr.pop_front()); void'(q_data.pop_front());
    end
    if (mem_valid && mem_addr != 5'd0) begin
      if (q_addr.size() < DEPTH) begin q_addr.push_back(mem_addr); q_data.push_back(mem_data); end
      else m_ovf = 1'b1;
    end
    if (alu_valid && alu_addr != 5'd0) begin
      if (q_addr.size() < DEPTH) begin q_addr.push_back(alu_addr); q_data.push_back(alu_data); end
      else m_ovf = 1'b1;
    end
  endtask

  task automatic drive(bit mv, logic [4:0] ma, logic [31:0] md, bit av, logic [4:0] aa,
                       logic [31:0] ad, logic [4:0] a1, logic [4:0] a2);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    addr1 = a1; addr2 = a2;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    add(0,0,0,                0,0,0,                0,0, mk(0,0,0,0,0,1,0));
    add(0,0,0,                1,5,32'hDEADBEEF,     5,0, mk(0,0,0,0,0,1,0));
    add(0,0,0,                0,0,0,                5,0, mk(1,5,32'hDEADBEEF,1,0,1,0));
    add(0,0,0,                0,0,0,                5,0, mk(0,0,0,0,0,1,0));
    add(1,3,32'h11,           1,3,32'h22,           3,3, mk(0,0,0,0,0,1,0));
    add(0,0,0,                0,0,0,                3,7, mk(1,3,32'h11,1,0,1,0));
    add(0,0,0,                0,0,0,                3,7, mk(1,3,32'h22,1,0,1,0));
    add(0,0,0,                0,0,0,                3,7, mk(0,0,0,0,0,1,0));
    add(1,0,32'hFFFF,         1,0,32'h1234,         0,0, mk(0,0,0,0,0,1,0));
    add(0,0,0,                0,0,0,                0,0, mk(0,0,0,0,0,1,0));
    add(1,1,32'hA1,           1,2,32'hA2,           1,2, mk(0,0,0,0,0,1,0));
    add(1,3,32'hA3,           1,4,32'hA4,           1,2, mk(1,1,32'hA1,1,1,1,0));
    add(1,6,32'hA6,           1,7,32'hA7,           1,4, mk(1,2,32'hA2,0,1,1,0));
    add(1,8,32'hA8,           1,9,32'hA9,           7,9, mk(1,3,32'hA3,1,0,0,0));
    add(0,0,0,                0,0,0,                9,8, mk(1,4,32'hA4,0,1,0,1));
    add(0,0,0,                0,0,0,                0,0, mk(1,6,32'hA6,0,0,1,1));
    add(0,0,0,                0,0,0,                7,0, mk(1,7,32'hA7,1,0,1,1));
    add(0,0,0,                0,0,0,                7,8, mk(1,8,32'hA8,0,1,1,1));
    add(0,0,0,                0,0,0,                8,0, mk(0,0,0,0,0,1,1));

    for (int i = 0; i < vtab.size(); i++) begin
      drive(vtab[i].mv, vtab[i].ma, vtab[i].md, vtab[i].av, vtab[i].aa, vtab[i].ad, vtab[i].a1, vtab[i].a2);
      #1;
      check($sformatf("vec%0d", i), actual(), vtab[i].exp);
      advance();
    end

    // Forwarding picks the younger of two same-register entries
    drive(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 5'd0, 5'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
    #1;
`ifdef WB_FORWARD_EN
    check_fwd("fwd_both_queued", 32'h22, 32'h22);
`else
    check_fwd("fwd_both_queued", 32'h0, 32'h0);
`endif
    check("fwd_both_pend", actual(), mk(1,3,32'h11,1,1,1,1));
    advance();
    #1;
    check_fwd("fwd_one_left", youngest(5'd3), youngest(5'd3));
    advance();
    #1;
    check_fwd("fwd_drained", 32'h0, 32'h0);

    // Asynchronous reset with three entries queued
    drive(1, 5'd1, 32'hB1, 1, 5'd2, 32'hB2, 5'd2, 5'd0);
    advance();
    drive(1, 5'd3, 32'hB3, 1, 5'd4, 32'hB4, 5'd2, 5'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 5'd2, 5'd0);
    #1;
    check("rst_pre", actual(), mk(1,2,32'hB2,1,0,1,1));
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_async", actual(), mk(0,0,0,0,0,1,0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rst_after%0d", i), actual(), mk(0,0,0,0,0,1,0));
      advance();
    end

    // Random traffic, mostly respecting wb_ready so overflow stays rare but reachable
    do_reset();
    for (int i = 0; i < 400; i++) begin
      obs_t  m = model_obs();
      bit    ok = ($urandom_range(0, 9) != 0) ? m.wb_ready : 1'b1;
      drive(ok && $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            ok && $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      check($sformatf("rnd%0d", i), actual(), model_obs());
      check_fwd($sformatf("rnd_fwd%0d", i), youngest(addr1), youngest(addr2));
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
